// File: rtl/sd_dac8_pkg.sv
// sd_dac_pkg: shared state encoding and default sizing for the delta-sigma DAC
package sd_dac_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int WIDTH_DEFAULT = 8;
    localparam int OSR_DEFAULT = 256;
endpackage

// File: rtl/sd_dac8_if.sv
// sd_dac8_if: valid/ready code input channel
interface sd_dac8_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] digital_in;
    logic             in_valid;
    logic             in_ready;
    modport master (output digital_in, in_valid, input in_ready);
    modport slave  (input digital_in, in_valid, output in_ready);
endinterface

// File: rtl/sd_dac8_mod.sv
// sd_dac_mod: first-order modulator, carry of acc + code is the output bit
module sd_dac_mod #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             run,
    input  logic [WIDTH-1:0] code,
    output logic             dout
);
    logic [WIDTH-1:0] acc;
    // accumulate the held code; the carry out becomes the registered bit
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {dout, acc} <= '0;
        else if (clr) {dout, acc} <= '0;
        else if (run) {dout, acc} <= {1'b0, acc} + {1'b0, code};
endmodule

// File: rtl/sd_dac8.sv
// sd_dac8: 8-bit delta-sigma DAC with two-deep code buffer and sample timing
module sd_dac8 import sd_dac_pkg::*; #(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int OSR   = OSR_DEFAULT,
    parameter int OSR_W = $clog2(OSR)
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      enable,
    sd_dac8_if.slave  bus,
    output logic      bit_out,
    output logic      sample_tick,
    output logic      underrun,
    output logic      busy
);
    state_t           state, state_nx;
    logic [WIDTH-1:0] hold, next_code;
    logic             next_full, period_end, load;
    logic [OSR_W-1:0] osr_cnt;

    // next state, handshake and buffer transfer decode
    always_comb begin
        busy = state == RUN;
        bus.in_ready = enable && !next_full;
        period_end = busy && osr_cnt == OSR_W'(OSR - 1);
        load = enable && next_full && (!busy || period_end);
        state_nx = enable && (busy || next_full) ? RUN : IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;

    // code buffer, sample counter and period-end flags
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            hold <= '0;
            next_code <= '0;
            next_full <= 1'b0;
            osr_cnt <= '0;
            sample_tick <= 1'b0;
            underrun <= 1'b0;
        end else if (!enable) begin
            next_full <= 1'b0;
            osr_cnt <= '0;
            sample_tick <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                next_code <= bus.digital_in;
                next_full <= 1'b1;
            end else if (load) next_full <= 1'b0;
            if (load) hold <= next_code;
            osr_cnt <= busy ? osr_cnt + 1'b1 : '0;
            sample_tick <= period_end;
            underrun <= period_end && !next_full;
        end

    sd_dac_mod #(.WIDTH(WIDTH)) u_mod (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!enable || !busy),
        .run   (busy),
        .code  (hold),
        .dout  (bit_out)
    );
endmodule

// File: tb/tb_sd_dac8.sv
// tb_sd_dac8: directed checks of handshake, density, underrun, enable and reset
module tb_sd_dac8;
    logic clk = 1'b0, rst_n, enable;
    logic bit_out, sample_tick, underrun, busy;
    int errors = 0, checks = 0;
    int ones, cycles, ticks, uns, tu, early;
    int per_ones[$], per_cyc[$];
    logic [7:0] sh;
    logic auto_push = 1'b0;

    sd_dac8_if #(.WIDTH(8)) bus();

    sd_dac8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .bus         (bus),
        .bit_out     (bit_out),
        .sample_tick (sample_tick),
        .underrun    (underrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic reset_stats();
        ones = 0; cycles = 0; ticks = 0; uns = 0; tu = 0; sh = '0;
        per_ones.delete(); per_cyc.delete();
    endtask

    task automatic cyc();
        @(negedge clk);
        ones += int'(bit_out);
        cycles++;
        sh = {sh[6:0], bit_out};
        if (sample_tick) begin
            per_ones.push_back(ones);
            per_cyc.push_back(cycles);
            ones = 0; cycles = 0; ticks++;
        end
        if (underrun) uns++;
        if (underrun && sample_tick) tu++;
        if (auto_push) begin
            bus.in_valid = bus.in_ready;
            bus.digital_in = 8'h40;
        end
    endtask

    task automatic push(input logic [7:0] c);
        bus.digital_in = c;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 600 && !bus.in_ready; i++) cyc();
        if (!bus.in_ready) check("push_timeout", 0, 1);
        cyc();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_tick(input string tag);
        for (int i = 0; i < 600; i++) begin
            cyc();
            if (sample_tick) break;
        end
        check(tag, sample_tick, 1);
    endtask

    task automatic clear();
        bus.in_valid = 1'b0;
        enable = 1'b0;
        cyc();
        enable = 1'b1;
        cyc();
    endtask

    task automatic s_steady(input string p);
        reset_stats();
        bus.digital_in = 8'h40;
        bus.in_valid = 1'b1;
        cyc();
        bus.in_valid = 1'b0;
        check({p, "_busy_lo"}, busy, 0);
        cyc();
        check({p, "_busy_hi"}, busy, 1);
        auto_push = 1'b1;
        repeat (1100) cyc();
        auto_push = 1'b0;
        bus.in_valid = 1'b0;
        check({p, "_ticks"}, int'(ticks >= 4), 1);
        foreach (per_ones[i]) check({p, "_ones64"}, per_ones[i], 64);
        check({p, "_underrun"}, uns, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b0;
        bus.in_valid = 1'b0; bus.digital_in = '0;
        #12;
        check("rst_ready_dis", bus.in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_bit", bit_out, 0);
        check("rst_tick", sample_tick, 0);
        check("rst_underrun", underrun, 0);
        enable = 1'b1;
        #1 check("rst_ready_en", bus.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        reset_stats();
        repeat (1000) cyc();
        check("idle_ticks", ticks, 0);
        check("idle_ones", ones, 0);
        check("idle_busy", busy, 0);

        s_steady("s40");

        clear();
        reset_stats();
        push(8'h00);
        push(8'hFF);
        check("s3_rdy_drop", bus.in_ready, 0);
        early = 0;
        for (int i = 0; i < 600 && !sample_tick; i++) begin
            cyc();
            if (!sample_tick && bus.in_ready) early++;
        end
        check("s3_rdy_early", early, 0);
        check("s3_tick1", sample_tick, 1);
        check("s3_rdy_rise", bus.in_ready, 1);
        wait_tick("s3_tick2");
        check("s3_periods", per_ones.size(), 2);
        if (per_ones.size() >= 2) begin
            check("s3_ones00", per_ones[0], 0);
            check("s3_onesFF", per_ones[1], 255);
            check("s3_len", per_cyc[1], 256);
        end

        clear();
        reset_stats();
        push(8'h80);
        wait_tick("s4_tick1");
        wait_tick("s4_tick2");
        wait_tick("s4_tick3");
        check("s4_tick_un", tu, 3);
        check("s4_un_total", uns, 3);
        foreach (per_ones[i]) check("s4_ones128", per_ones[i], 128);
        check("s4_toggle", sh, 8'h55);

        clear();
        reset_stats();
        push(8'h40);
        push(8'h40);
        repeat (50) cyc();
        check("s5_busy_run", busy, 1);
        enable = 1'b0;
        cyc();
        check("s5_busy", busy, 0);
        check("s5_bit", bit_out, 0);
        check("s5_ready_dis", bus.in_ready, 0);
        check("s5_tick", sample_tick, 0);
        enable = 1'b1;
        #1 check("s5_ready_en", bus.in_ready, 1);
        reset_stats();
        repeat (600) cyc();
        check("s5_no_tick", ticks, 0);
        check("s5_idle", busy, 0);

        clear();
        reset_stats();
        auto_push = 1'b1;
        repeat (300) cyc();
        for (int i = 0; i < 8 && !bit_out; i++) cyc();
        check("s6_bit_pre", bit_out, 1);
        auto_push = 1'b0;
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("s6_bit", bit_out, 0);
        check("s6_tick", sample_tick, 0);
        check("s6_underrun", underrun, 0);
        check("s6_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_steady("s6r");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
